des_key_sched: RTL and testbench

- Iterative DES key schedule. Sits directly upstream of the DES round datapath.
- Each 48-bit subkey it produces is XORed with the expanded right half, and the result forms the 6-bit inputs of the S-box substitution blocks (sb1..sb8).
- Loads a 64-bit key and applies PC-1. It then issues K1..K16 (encrypt) or K16..K1 (decrypt), one subkey per advance, over a valid/advance handshake.

---
 rtl/des_pkg.sv | 42 ++++
 rtl/des_pc2.sv | 12 +
 rtl/des_key_sched.sv | 81 ++++++++
 tb/tb_des_key_sched.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: DES key schedule tables, types and helpers (PC-1, PC-2, SHIFT, rotations, byte parity)
package des_pkg;
  typedef logic [47:0] subkey_t;
  typedef logic [27:0] half_t;
  typedef enum logic {IDLE, ISSUE} ks_state_t;
  // Tables use DES bit numbering: entry i names the 1-based source bit of output bit i+1.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };
  localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  function automatic logic [55:0] pc1(input logic [63:0] k);
    pc1 = '0;
    for (int i = 0; i < 56; i++) pc1[55-i] = k[64-PC1[i]];
  endfunction
  function automatic half_t rol(input half_t h, input int n);
    return (n == 2) ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
  endfunction
  function automatic half_t ror(input half_t h, input int n);
    return (n == 2) ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
  endfunction
  function automatic logic odd_parity(input logic [63:0] k);
    odd_parity = 1'b1;
    for (int i = 0; i < 8; i++) odd_parity = odd_parity & (^k[8*i+:8]);
  endfunction
endpackage

// File: rtl/des_pc2.sv
// des_pc2: combinational PC-2 compression of the 56-bit C||D register into a 48-bit subkey (cd in, subkey out)
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);
  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) subkey[47-i] = cd[56-PC2[i]];
  end
endmodule

// File: rtl/des_key_sched.sv
// des_key_sched: iterative DES key schedule issuing K1..K16 (or K16..K1) over a valid/advance handshake.
// Ports: clk, rst (sync, active-high), key_load/key_in/decrypt load a key, next_key advances,
// subkey_out/subkey_valid/round_num present the current subkey, busy while issuing, done pulses at the end,
// parity_err flags a rejected key. Optional macro DES_PARITY_CHK_EN enables odd-parity key checking.
module des_key_sched
  import des_pkg::*;
#(
  parameter bit AUTO_ADV = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        next_key,
  output logic [47:0] subkey_out,
  output logic        subkey_valid,
  output logic [3:0]  round_num,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);
  ks_state_t state, state_n;
  half_t c, d;
  logic dec, key_ok, adv, last;
  logic [55:0] cd_key;
  logic [3:0] nxt, rev;
  assign cd_key = pc1(key_in);
  assign adv = (state == ISSUE) && (next_key || AUTO_ADV);
  assign last = round_num == 4'd15;
  assign nxt = round_num + 4'd1;
  assign rev = 4'd15 - round_num;
`ifdef DES_PARITY_CHK_EN
  assign key_ok = odd_parity(key_in);
  always_ff @(posedge clk)
    if (rst) parity_err <= 1'b0;
    else if (key_load) parity_err <= !key_ok;
`else
  assign key_ok = 1'b1;
  assign parity_err = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = key_load ? (key_ok ? ISSUE : IDLE) : (adv && last) ? IDLE : state;
  always_comb begin
    subkey_valid = state == ISSUE;
    busy = state == ISSUE;
  end
  // Encrypt pre-rotates by SHIFT[0] on load so K1 is ready; decrypt starts from C0=C16 for K16.
  always_ff @(posedge clk)
    if (rst) begin
      c <= '0;
      d <= '0;
      dec <= 1'b0;
      round_num <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (key_load) begin
        round_num <= '0;
        if (key_ok) begin
          dec <= decrypt;
          c <= decrypt ? cd_key[55:28] : rol(cd_key[55:28], SHIFT[0]);
          d <= decrypt ? cd_key[27:0] : rol(cd_key[27:0], SHIFT[0]);
        end
      end else if (adv) begin
        round_num <= last ? 4'd0 : nxt;
        done <= last;
        if (!last) begin
          c <= dec ? ror(c, SHIFT[rev]) : rol(c, SHIFT[nxt]);
          d <= dec ? ror(d, SHIFT[rev]) : rol(d, SHIFT[nxt]);
        end
      end
    end
  des_pc2 u_pc2 (
    .cd(({c, d})),
    .subkey(subkey_out)
  );
endmodule

// File: tb/tb_des_key_sched.sv
// tb_des_key_sched: directed plus randomized checks of des_key_sched against an independent subkey model
module tb_des_key_sched;
  logic clk = 1'b0, rst = 1'b1, key_load = 1'b0, decrypt = 1'b0, next_key = 1'b0;
  logic [63:0] key_in = '0;
  logic [47:0] subkey_out;
  logic subkey_valid, busy, done, parity_err;
  logic [3:0] round_num;
  int errors = 0, checks = 0;
  logic [47:0] km [1:16];
  logic [47:0] enc_seq [16];
  int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int sh_t [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1_A = 48'h1B02EFFC7072;
  localparam logic [47:0] K16_A = 48'hCB3D8B0E17F5;

  des_key_sched dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .decrypt(decrypt), .next_key(next_key),
    .subkey_out(subkey_out), .subkey_valid(subkey_valid), .round_num(round_num), .busy(busy),
    .done(done), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Straight from the DES definition: cumulative rotations of C and D, PC-2 applied after each round.
  task automatic model(input logic [63:0] k);
    logic [27:0] c, d;
    logic [55:0] cd;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-pc1_t[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 1; n <= 16; n++) begin
      int s;
      s = sh_t[n-1];
      c = (c << s) | (c >> (28 - s));
      d = (d << s) | (d >> (28 - s));
      cd = {c, d};
      for (int j = 0; j < 48; j++) km[n][47-j] = cd[56-pc2_t[j]];
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, subkey_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_round"}, round_num, 0);
    check({tag, "_subkey"}, subkey_out, 0);
    check({tag, "_perr"}, parity_err, 0);
  endtask

  task automatic load(input logic [63:0] k, input logic dec, input logic nk);
    key_in = k;
    decrypt = dec;
    next_key = nk;
    key_load = 1'b1;
    step;
    key_load = 1'b0;
  endtask

  task automatic run_full(input logic dec, input string tag);
    next_key = 1'b1;
    for (int r = 0; r < 16; r++) begin
      check({tag, "_subkey"}, subkey_out, dec ? km[16-r] : km[r+1]);
      check({tag, "_round"}, round_num, r);
      check({tag, "_valid"}, subkey_valid, 1);
      check({tag, "_done_early"}, done, 0);
      if (dec) check({tag, "_reverse"}, subkey_out, enc_seq[15-r]);
      else enc_seq[r] = subkey_out;
      step;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_valid_end"}, subkey_valid, 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_round_end"}, round_num, 0);
    next_key = 1'b0;
    step;
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    logic [63:0] k;
    logic dec, nk, fin;
    int r, cyc;
    step;
    check_reset("reset");
    rst = 1'b0;
    model(KEY_A);
    // encrypt order, next_key held high
    load(KEY_A, 1'b0, 1'b1);
    check("enc_k1_vector", subkey_out, K1_A);
    run_full(1'b0, "enc");
    check("enc_k16_vector", enc_seq[15], K16_A);
    // decrypt order
    load(KEY_A, 1'b1, 1'b1);
    check("dec_first_vector", subkey_out, K16_A);
    run_full(1'b1, "dec");
    // stall after load
    load(KEY_A, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall_subkey", subkey_out, K1_A);
      check("stall_round", round_num, 0);
      check("stall_done", done, 0);
      step;
    end
    run_full(1'b0, "stall_resume");
    // mid-schedule reload with next_key high in the same cycle
    load(KEY_A, 1'b0, 1'b1);
    repeat (7) step;
    check("reload_pre_round", round_num, 7);
    k = 64'h0E329232EA6D0D73;
    model(k);
    load(k, 1'b0, 1'b1);
    check("reload_round", round_num, 0);
    check("reload_done", done, 0);
    run_full(1'b0, "reload");
    // synchronous reset mid-schedule
    model(KEY_A);
    load(KEY_A, 1'b0, 1'b1);
    repeat (9) step;
    check("rst_pre_round", round_num, 9);
    rst = 1'b1;
    #2;
    check("rst_between_round", round_num, 9);
    check("rst_between_valid", subkey_valid, 1);
    check("rst_between_subkey", subkey_out, km[10]);
    next_key = 1'b0;
    step;
    check_reset("rst_mid");
    rst = 1'b0;
`ifdef DES_PARITY_CHK_EN
    load(64'h0, 1'b0, 1'b0);
    check("par_err", parity_err, 1);
    check("par_valid", subkey_valid, 0);
    step;
    check("par_err_hold", parity_err, 1);
    load(KEY_A, 1'b0, 1'b0);
    check("par_clear", parity_err, 0);
    check("par_k1", subkey_out, K1_A);
    check("par_valid_good", subkey_valid, 1);
`endif
    // randomized keys, direction and stalls
    for (int t = 0; t < 6; t++) begin
      k = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) k[8*b] = ~(^k[8*b+1+:7]);
      dec = 1'($urandom_range(1));
      model(k);
      load(k, dec, 1'b0);
      r = 0;
      fin = 1'b0;
      cyc = 0;
      while (!fin && cyc < 300) begin
        nk = 1'($urandom_range(1));
        next_key = nk;
        check("rand_subkey", subkey_out, dec ? km[16-r] : km[r+1]);
        check("rand_round", round_num, r);
        step;
        cyc++;
        if (nk) begin
          if (r == 15) fin = 1'b1;
          else r++;
        end
        if (!fin) check("rand_no_done", done, 0);
      end
      check("rand_bound", fin, 1);
      check("rand_done", done, 1);
      next_key = 1'b0;
      step;
      check("rand_idle", subkey_valid, 0);
    end
    check("final_perr", parity_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
